// File: rtl/nibble_adder_pkg.sv
// Shared types and constants for the nibble-serial adder: nibble width, FSM state
// type and the nibble-count helper.
package nibble_adder_pkg;

  localparam int unsigned NIB_W = 4;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDone
  } state_e;

  function automatic int unsigned nib_count(input int unsigned width);
    return width / NIB_W;
  endfunction

endpackage

// File: rtl/nibble_serial_adder_cla4_slice.sv
// Combinational 4-bit carry-lookahead slice; exports the carry into bit 3 so the
// caller can derive signed overflow.
module cla4_slice
  import nibble_adder_pkg::*;
(
  input  logic [NIB_W-1:0] a_i,
  input  logic [NIB_W-1:0] b_i,
  input  logic             ci_i,
  output logic [NIB_W-1:0] s_o,
  output logic             co_o,
  output logic             c3_o
);

  logic [NIB_W-1:0] p;
  logic [NIB_W-1:0] g;
  logic [NIB_W:0]   c;

  always_comb begin
    p    = a_i ^ b_i;
    g    = a_i & b_i;
    // Each carry is flattened from the generate/propagate terms, not chained.
    c[0] = ci_i;
    c[1] = g[0] | (p[0] & ci_i);
    c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & ci_i);
    c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & ci_i);
    c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
         | (p[3] & p[2] & p[1] & p[0] & ci_i);
    s_o  = p ^ c[NIB_W-1:0];
    co_o = c[4];
    c3_o = c[3];
  end

endmodule

// File: rtl/nibble_serial_adder.sv
// WIDTH-bit adder that walks one nibble per cycle through a single CLA slice.
// Define NIBBLE_SERIAL_OVF_EN to add the registered signed-overflow output ovf.
module nibble_serial_adder
  import nibble_adder_pkg::*;
#(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout
`ifdef NIBBLE_SERIAL_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int unsigned NIB  = nib_count(WIDTH);
  localparam int unsigned IdxW = (NIB > 1) ? $clog2(NIB) : 1;
  localparam logic [IdxW-1:0] LastIdx = IdxW'(NIB - 1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             carry_q, carry_d;
  logic             cout_q, cout_d;
  logic [IdxW-1:0]  idx_q, idx_d;

  logic [NIB_W-1:0] slice_s;
  logic             slice_co;

`ifdef NIBBLE_SERIAL_OVF_EN
  logic slice_c3;
  logic ovf_q, ovf_d;
`endif

  // Operands are shifted right each cycle, so the slice always sees the low nibble.
  cla4_slice u_slice (
    .a_i  (a_q[NIB_W-1:0]),
    .b_i  (b_q[NIB_W-1:0]),
    .ci_i (carry_q),
    .s_o  (slice_s),
    .co_o (slice_co),
`ifdef NIBBLE_SERIAL_OVF_EN
    .c3_o (slice_c3)
`else
    .c3_o ()
`endif
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: if (in_valid) state_d = StRun;
      StRun:  if (idx_q == LastIdx) state_d = StDone;
      StDone: if (out_ready) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    in_ready  = (state_q == StIdle);
    out_valid = (state_q == StDone);
    sum       = sum_q;
    cout      = cout_q;
`ifdef NIBBLE_SERIAL_OVF_EN
    ovf       = ovf_q;
`endif
  end

  always_comb begin
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    idx_d   = idx_q;
`ifdef NIBBLE_SERIAL_OVF_EN
    ovf_d   = ovf_q;
`endif
    if (state_q == StIdle && in_valid) begin
      a_d     = a;
      b_d     = b;
      carry_d = cin;
      idx_d   = '0;
    end else if (state_q == StRun) begin
      a_d     = a_q >> NIB_W;
      b_d     = b_q >> NIB_W;
      carry_d = slice_co;
      sum_d[int'(idx_q) * NIB_W +: NIB_W] = slice_s;
      if (idx_q == LastIdx) begin
        cout_d = slice_co;
`ifdef NIBBLE_SERIAL_OVF_EN
        ovf_d  = slice_c3 ^ slice_co;
`endif
      end else begin
        idx_d = idx_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      idx_q   <= '0;
    end else begin
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      idx_q   <= idx_d;
    end
  end

`ifdef NIBBLE_SERIAL_OVF_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
    end
  end
`endif

endmodule

// File: tb/tb_nibble_serial_adder.sv
// Directed, table-driven bench for nibble_serial_adder (WIDTH=16), with hand-written
// sequences for back-pressure and mid-operation reset.
module tb_nibble_serial_adder;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] a;
  logic [15:0] b;
  logic        cin;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] sum;
  logic        cout;
`ifdef NIBBLE_SERIAL_OVF_EN
  logic        ovf;
`endif

  int checks = 0;
  int errors = 0;

  nibble_serial_adder #(.WIDTH(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout)
`ifdef NIBBLE_SERIAL_OVF_EN
    ,
    .ovf       (ovf)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    logic [15:0] exp_sum;
    logic        exp_cout;
    logic        exp_ovf;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Accept one operand set, count edges until out_valid, then consume the result.
  task automatic do_op(input logic [15:0] va, input logic [15:0] vb, input logic vc,
                       output logic [15:0] rs, output logic rc, output logic ro,
                       output int lat);
    @(negedge clk);
    in_valid = 1'b1;
    a = va;
    b = vb;
    cin = vc;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    lat = 0;
    rs = 'x;
    rc = 1'bx;
    ro = 1'bx;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #1;
      lat++;
      if (out_valid) break;
    end
    if (!out_valid) begin
      chk("out_valid_timeout", 32'(out_valid), 32'd1);
      return;
    end
    rs = sum;
    rc = cout;
`ifdef NIBBLE_SERIAL_OVF_EN
    ro = ovf;
`else
    ro = 1'b0;
`endif
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
  endtask

  vec_t vecs[10];

  initial begin
    logic [15:0] rs;
    logic        rc;
    logic        ro;
    int          lat;

    vecs[0] = '{16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0};
    vecs[1] = '{16'hFFFF, 16'h0000, 1'b1, 16'h0000, 1'b1, 1'b0};
    vecs[2] = '{16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1, 1'b0};
    vecs[3] = '{16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1};
    vecs[4] = '{16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0};
    vecs[5] = '{16'hABCD, 16'h1111, 1'b0, 16'hBCDE, 1'b0, 1'b0};
    vecs[6] = '{16'h0F0F, 16'h00F1, 1'b0, 16'h1000, 1'b0, 1'b0};
    vecs[7] = '{16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1};
    vecs[8] = '{16'h0000, 16'h0000, 1'b1, 16'h0001, 1'b0, 1'b0};
    vecs[9] = '{16'h5A5A, 16'hA5A5, 1'b0, 16'hFFFF, 1'b0, 1'b0};

    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    a = '0;
    b = '0;
    cin = 1'b0;
    #12;
    chk("reset_in_ready", 32'(in_ready), 32'd1);
    chk("reset_out_valid", 32'(out_valid), 32'd0);
    chk("reset_sum", 32'(sum), 32'h0);
    chk("reset_cout", 32'(cout), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 10; i++) begin
      do_op(vecs[i].a, vecs[i].b, vecs[i].cin, rs, rc, ro, lat);
      chk($sformatf("vec%0d_latency", i), 32'(lat), 32'd4);
      chk($sformatf("vec%0d_sum", i), 32'(rs), 32'(vecs[i].exp_sum));
      chk($sformatf("vec%0d_cout", i), 32'(rc), 32'(vecs[i].exp_cout));
`ifdef NIBBLE_SERIAL_OVF_EN
      chk($sformatf("vec%0d_ovf", i), 32'(ro), 32'(vecs[i].exp_ovf));
`endif
      chk($sformatf("vec%0d_drop_valid", i), 32'(out_valid), 32'd0);
      chk($sformatf("vec%0d_idle_ready", i), 32'(in_ready), 32'd1);
    end

    // Back-pressure: result held for 5 cycles while new operands are offered.
    @(negedge clk);
    in_valid = 1'b1;
    a = 16'h00F0;
    b = 16'h0010;
    cin = 1'b0;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("hold_run%0d_in_ready", i), 32'(in_ready), 32'd0);
      @(posedge clk);
      #1;
    end
    chk("hold_out_valid_rise", 32'(out_valid), 32'd1);
    for (int i = 0; i < 5; i++) begin
      in_valid = i[0];
      a = 16'hFFFF;
      b = 16'hFFFF;
      cin = 1'b1;
      @(posedge clk);
      #1;
      chk($sformatf("hold%0d_sum", i), 32'(sum), 32'h0100);
      chk($sformatf("hold%0d_cout", i), 32'(cout), 32'd0);
      chk($sformatf("hold%0d_out_valid", i), 32'(out_valid), 32'd1);
      chk($sformatf("hold%0d_in_ready", i), 32'(in_ready), 32'd0);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    chk("hold_release_out_valid", 32'(out_valid), 32'd0);
    chk("hold_release_in_ready", 32'(in_ready), 32'd1);

    // Reset asserted in the second RUN cycle discards the operation.
    @(negedge clk);
    in_valid = 1'b1;
    a = 16'h8000;
    b = 16'h8000;
    cin = 1'b0;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    chk("midrst_in_ready", 32'(in_ready), 32'd1);
    chk("midrst_out_valid", 32'(out_valid), 32'd0);
    chk("midrst_sum", 32'(sum), 32'h0);
    chk("midrst_cout", 32'(cout), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk);
      #1;
      chk($sformatf("midrst_quiet%0d", i), 32'({out_valid, in_ready}), 32'b01);
    end
    do_op(16'h0001, 16'h0001, 1'b0, rs, rc, ro, lat);
    chk("postrst_latency", 32'(lat), 32'd4);
    chk("postrst_sum", 32'(rs), 32'h0002);
    chk("postrst_cout", 32'(rc), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/nibble_serial_adder.md
Name: nibble_serial_adder

Overview:
- Multi-cycle wide adder that accepts WIDTH-bit operands over a valid/ready handshake.
- Feeds them one 4-bit nibble per cycle, LSB first, through a single 4-bit carry-lookahead slice, with the carry held in a register between nibbles.
- Reassembles the WIDTH-bit sum and carry-out and presents them on an output valid/ready handshake.
- Sits between the operand source and the result consumer; trades latency for area against a fully parallel multi-level lookahead adder.

Parameters:
- WIDTH, 16, operand/sum width in bits; must be a multiple of 4 and at least 8.
- NIB, WIDTH/4, derived nibble count; not overridable.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- in_valid  input  1  operand set present
- in_ready  output  1  block can accept operands
- a  input  WIDTH  operand A
- b  input  WIDTH  operand B
- cin  input  1  carry-in to nibble 0
- out_valid  output  1  result present
- out_ready  input  1  consumer accepts result
- sum  output  WIDTH  registered sum
- cout  output  1  registered carry-out of the top nibble

Behaviour:
- Clock and reset: one clock, clk. Reset rst is asynchronous and active-high.
- Reset values: state=IDLE, in_ready=1, out_valid=0, sum=0, cout=0; internal operand regs, carry reg and nibble index all cleared.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid=1: capture a, b, cin into operand shift regs and carry reg; idx<=0; go to RUN.
- RUN:
  - in_ready=0, out_valid=0.
  - Each cycle: slice adds a_nib[idx] + b_nib[idx] + carry_reg. Write the sum nibble into sum[4*idx+3:4*idx]; carry_reg <= slice carry-out.
  - idx==NIB-1: also cout <= slice carry-out; go to DONE. Otherwise idx<=idx+1.
- DONE:
  - out_valid=1; sum and cout held stable.
  - On out_ready=1: go to IDLE and drop out_valid next cycle.
  - in_ready stays 0 in DONE. There is no overlap of a new operation with an unconsumed result.
- Latency: out_valid is first high NIB cycles after the accepting edge (4 for WIDTH=16). Throughput: one result per NIB+2 cycles with out_ready held high.
- Slice arithmetic:
  - P=a^b, G=a&b.
  - c1=G0|P0c0; c2=G1|P1c1; c3=G2|P2c2; co=G3|P3c3.
  - s[i]=P[i]^c[i], using per-bit carries, not carry-in alone.
- Width rule: result is (WIDTH+1) bits {cout,sum}, modulo 2^(WIDTH+1); no truncation of the carry.
- in_valid in RUN/DONE: ignored (in_ready=0). Source must hold operands until in_ready.
- out_ready high outside DONE: no effect.
- Reset mid-RUN or mid-DONE: in-flight operation discarded; all outputs return to reset values immediately (asynchronous).
- sum bits from a previous result stay visible during RUN until overwritten. They are meaningful only while out_valid=1.

Optional Feature:
- Macro: NIBBLE_SERIAL_OVF_EN.
- Defined:
  - Extra output port ovf (output, 1), signed two's-complement overflow = carry into MSB XOR carry out of MSB, taken from the last nibble (c3^co).
  - Registered with cout, reset 0, valid only with out_valid.
- Undefined: port ovf absent; no extra logic.

Decomposition:
- Shared package nibble_adder_pkg:
  - NIB_W=4 constant.
  - state enum type (IDLE, RUN, DONE).
  - function for nibble count from WIDTH.
- One sub-module, cla4_slice: combinational 4-bit lookahead slice (a4, b4, ci -> s4, co, plus c3 for overflow), instantiated once.

Test Plan:
- a=0x1234, b=0x4321, cin=0 -> out_valid 4 cycles after accept; sum=0x5555, cout=0.
- a=0xFFFF, b=0x0000, cin=1 -> carry ripples through all four nibbles: sum=0x0000, cout=1.
- a=0xFFFF, b=0xFFFF, cin=1 -> sum=0xFFFF, cout=1; each nibble s=0xF.
- a=0x00F0, b=0x0010, out_ready held low 5 cycles after out_valid -> sum=0x0100 stable, in_ready=0 throughout, in_valid pulses ignored; out_ready=1 -> IDLE next cycle.
- Accept 0x8000+0x8000, assert rst in second RUN cycle -> out_valid never rises, in_ready=1 after reset; next op 0x0001+0x0001 returns 0x0002, cout=0.
- NIBBLE_SERIAL_OVF_EN defined: 0x7FFF+0x0001 -> sum=0x8000, cout=0, ovf=1; 0xFFFF+0x0001 -> ovf=0, cout=1.
